spi_slave_param: RTL and testbench

SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

---
 rtl/spi_slave_param.sv | 189 ++++++++++++++++++
 tb/tb_spi_slave_param.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_param.sv
// SPI slave: CLK-oversampled SCK/CS/MOSI, any CPOL/CPHA mode,
// parameterised word width and bit order, valid/ready word ports.
module spi_slave_param #(
  parameter int DATA_W      = 8,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CPOL,
  input  logic              CPHA,
  input  logic              I_spi_sck,
  input  logic              I_spi_cs,
  input  logic              I_spi_mosi,
  output logic              O_spi_miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic              clr_flags,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sck_q, cs_q, mosi_q;
  logic sck_s, cs_s, mosi_s, sck_d, cs_d;
  logic cpol_l, cpha_l;
  logic [DATA_W-1:0] hold, tx_sr, rx_sr;
  logic [DATA_W-1:0] rx_next, load_word;
  logic hold_full, load_pend;
  logic [CW-1:0] bit_cnt;
  logic cs_rise, cs_fall, sck_rise, sck_fall;
  logic lead, trail, start, stop, run;
  logic sample_e, shift_e, last, load;

  function automatic logic first_bit(
    input logic [DATA_W-1:0] w
  );
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] adv(
    input logic [DATA_W-1:0] w
  );
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // CS chain resets high so a CS held through reset
  // is not mistaken for a fresh select.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sck_q  <= '0;
      mosi_q <= '0;
      cs_q   <= '1;
      sck_d  <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-2:0], I_spi_sck};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], I_spi_mosi};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], I_spi_cs};
      sck_d  <= sck_s;
      cs_d   <= cs_s;
    end
  end

  assign sck_s    = sck_q[SYNC_STAGES-1];
  assign cs_s     = cs_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign lead     = cpol_l ? sck_fall : sck_rise;
  assign trail    = cpol_l ? sck_rise : sck_fall;

  assign start    = (state == IDLE) && cs_rise;
  assign stop     = (state == ACTIVE) && cs_fall;
  assign run      = (state == ACTIVE) && !cs_fall;
  assign sample_e = run && (cpha_l ? trail : lead);
  assign shift_e  = run && (cpha_l ? lead : trail);
  assign last     = sample_e && (bit_cnt == LAST);
  assign load     = start || (shift_e && load_pend);
  assign load_word = hold_full ? hold : '0;
  assign tx_ready = ~hold_full;

  assign rx_next = MSB_FIRST
    ? {rx_sr[DATA_W-2:0], mosi_s}
    : {mosi_s, rx_sr[DATA_W-1:1]};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cs_rise) state_nx = ACTIVE;
      ACTIVE:  if (cs_fall) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ACTIVE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cpol_l      <= 1'b0;
      cpha_l      <= 1'b0;
      hold        <= '0;
      hold_full   <= 1'b0;
      tx_sr       <= '0;
      load_pend   <= 1'b0;
      O_spi_miso  <= 1'b0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      if (start) begin
        cpol_l <= CPOL;
        cpha_l <= CPHA;
      end
      if (load) hold_full <= 1'b0;
      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
      // CPHA=1 holds the first bit back until the first leading edge
      if (stop) begin
        tx_sr      <= '0;
        O_spi_miso <= 1'b0;
        load_pend  <= 1'b0;
      end else if (start) begin
        load_pend <= 1'b0;
        if (CPHA) begin
          tx_sr      <= load_word;
          O_spi_miso <= 1'b0;
        end else begin
          tx_sr      <= adv(load_word);
          O_spi_miso <= first_bit(load_word);
        end
      end else if (shift_e) begin
        if (load_pend) begin
          load_pend  <= 1'b0;
          tx_sr      <= adv(load_word);
          O_spi_miso <= first_bit(load_word);
        end else begin
          tx_sr      <= adv(tx_sr);
          O_spi_miso <= first_bit(tx_sr);
        end
      end else if (state == IDLE) begin
        O_spi_miso <= 1'b0;
      end
      if (last) load_pend <= 1'b1;
      if (stop) begin
        rx_sr   <= '0;
        bit_cnt <= '0;
      end else if (sample_e) begin
        rx_sr   <= rx_next;
        bit_cnt <= last ? '0 : bit_cnt + CW'(1);
      end
      if (last && (!rx_valid || rx_ready)) begin
        rx_data  <= rx_next;
        rx_valid <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (last && rx_valid && !rx_ready) rx_overrun <= 1'b1;
      else if (clr_flags)                rx_overrun <= 1'b0;
      if (load && !hold_full) tx_underrun <= 1'b1;
      else if (clr_flags)     tx_underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: 8-bit MSB-first and 16-bit
// LSB-first instances driven by a bit-banged SPI master.
module tb_spi_slave_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpol = 1'b0, cpha = 1'b0;
  logic sck = 1'b0, mosi = 1'b0;
  logic cs0 = 1'b0, cs1 = 1'b0;

  logic       miso0, txv0 = 1'b0, trdy0;
  logic [7:0] txd0 = '0, rxd0;
  logic       rxv0, rrdy0 = 1'b0, clr0 = 1'b0;
  logic       ovr0, und0, busy0;

  logic        miso1, txv1 = 1'b0, trdy1;
  logic [15:0] txd1 = '0, rxd1;
  logic        rxv1, rrdy1 = 1'b0, clr1 = 1'b0;
  logic        ovr1, und1, busy1;

  int errs = 0;
  int checks = 0;
  logic [31:0] sb_rx[$];
  logic [31:0] sb_tx[$];
  int   rxv_cnt0 = 0;
  int   trdy_low0 = 0;
  logic rxv0_q = 1'b0;

  always #5 clk = ~clk;

  spi_slave_param #(
    .DATA_W(8), .MSB_FIRST(1'b1), .SYNC_STAGES(2)
  ) u_dut0 (
    .CLK(clk), .RESET(rst), .CPOL(cpol), .CPHA(cpha),
    .I_spi_sck(sck), .I_spi_cs(cs0), .I_spi_mosi(mosi),
    .O_spi_miso(miso0),
    .tx_data(txd0), .tx_valid(txv0), .tx_ready(trdy0),
    .rx_data(rxd0), .rx_valid(rxv0), .rx_ready(rrdy0),
    .clr_flags(clr0), .rx_overrun(ovr0),
    .tx_underrun(und0), .busy(busy0)
  );

  spi_slave_param #(
    .DATA_W(16), .MSB_FIRST(1'b0), .SYNC_STAGES(3)
  ) u_dut1 (
    .CLK(clk), .RESET(rst), .CPOL(cpol), .CPHA(cpha),
    .I_spi_sck(sck), .I_spi_cs(cs1), .I_spi_mosi(mosi),
    .O_spi_miso(miso1),
    .tx_data(txd1), .tx_valid(txv1), .tx_ready(trdy1),
    .rx_data(rxd1), .rx_valid(rxv1), .rx_ready(rrdy1),
    .clr_flags(clr1), .rx_overrun(ovr1),
    .tx_underrun(und1), .busy(busy1)
  );

  always @(posedge clk) begin
    rxv0_q <= rxv0;
    if (rxv0 && !rxv0_q) rxv_cnt0 <= rxv_cnt0 + 1;
  end

  always @(negedge clk) begin
    if (!trdy0) trdy_low0 <= trdy_low0 + 1;
  end

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tx_load(
    input bit sel,
    input logic [15:0] d
  );
    @(negedge clk);
    if (sel) begin
      txd1 = d;
      txv1 = 1'b1;
    end else begin
      txd0 = d[7:0];
      txv0 = 1'b1;
    end
    @(negedge clk);
    txv0 = 1'b0;
    txv1 = 1'b0;
  endtask

  task automatic clr(input bit sel);
    @(negedge clk);
    if (sel) clr1 = 1'b1;
    else     clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    clr1 = 1'b0;
  endtask

  task automatic frame(
    input  bit          sel,
    input  logic [1:0]  mode,
    input  int          w,
    input  bit          msb,
    input  logic [31:0] mo,
    input  int          nbits,
    input  bit          keep_cs,
    output logic [31:0] mi
  );
    int idx;
    mi = '0;
    @(negedge clk);
    cpol = mode[1];
    cpha = mode[0];
    sck  = mode[1];
    repeat (6) @(negedge clk);
    if (sel) cs1 = 1'b1;
    else     cs0 = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      idx = msb ? w - 1 - i : i;
      if (!cpha) begin
        mosi = mo[idx];
        #80;
        mi[idx] = sel ? miso1 : miso0;
        sck = ~cpol;
        #80;
        sck = cpol;
      end else begin
        sck  = ~cpol;
        mosi = mo[idx];
        #80;
        mi[idx] = sel ? miso1 : miso0;
        sck = cpol;
        #80;
      end
    end
    #80;
    if (!keep_cs) begin
      cs0 = 1'b0;
      cs1 = 1'b0;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic rx_take(
    input bit sel,
    input string tag
  );
    logic [31:0] exp;
    int n;
    n = 0;
    while (!(sel ? rxv1 : rxv0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    exp = sb_rx.pop_front();
    if (n >= 300) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk(tag, sel ? 32'(rxd1) : 32'(rxd0), exp);
    end
    if (sel) rrdy1 = 1'b1;
    else     rrdy0 = 1'b1;
    @(negedge clk);
    rrdy0 = 1'b0;
    rrdy1 = 1'b0;
    chk({tag, "_vclr"},
        32'(sel ? rxv1 : rxv0), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: no finish by 1ms");
    $fatal(1);
  end

  initial begin
    logic [31:0] mi;
    logic [15:0] txw [3];
    int c, t;
    txw = '{16'hBEEF, 16'h1357, 16'hC0DE};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst0", 32'({busy0, rxv0, miso0, trdy0, ovr0, und0}),
        32'b000100);
    chk("rst0_rxd", 32'(rxd0), 32'd0);
    chk("rst1", 32'({busy1, rxv1, miso1, trdy1, ovr1, und1}),
        32'b000100);
    chk("rst1_rxd", 32'(rxd1), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // mode 0, single byte
    tx_load(1'b0, 16'h00A5);
    chk("t38_trdy_full", 32'(trdy0), 32'd0);
    c = rxv_cnt0;
    sb_rx.push_back(32'h3C);
    sb_tx.push_back(32'hA5);
    frame(1'b0, 2'd0, 8, 1'b1, 32'h3C, 8, 1'b0, mi);
    chk("t38_miso", mi, sb_tx.pop_front());
    rx_take(1'b0, "t38_rx");
    chk("t38_nvalid", 32'(rxv_cnt0 - c), 32'd1);
    chk("t38_trdy_end", 32'(trdy0), 32'd1);

    // modes 1..3, 16-bit LSB-first
    for (int m = 1; m < 4; m++) begin
      tx_load(1'b1, txw[m-1]);
      sb_rx.push_back(32'h1234);
      sb_tx.push_back(32'(txw[m-1]));
      frame(1'b1, 2'(m), 16, 1'b0, 32'h1234, 16, 1'b0, mi);
      chk($sformatf("t39_m%0d_miso", m), mi,
          sb_tx.pop_front());
      rx_take(1'b1, $sformatf("t39_m%0d_rx", m));
    end

    // two words back-to-back, consumer stalled
    sb_rx.push_back(32'h5A);
    frame(1'b0, 2'd0, 16, 1'b1, 32'h5AC3, 16, 1'b0, mi);
    chk("t40_ovr", 32'(ovr0), 32'd1);
    chk("t40_valid", 32'(rxv0), 32'd1);
    clr(1'b0);
    chk("t40_ovr_clr", 32'(ovr0), 32'd0);
    rx_take(1'b0, "t40_rx");

    // nothing queued for transmit
    clr(1'b0);
    chk("t41_und_pre", 32'(und0), 32'd0);
    t = trdy_low0;
    sb_tx.push_back(32'h00);
    sb_rx.push_back(32'h96);
    frame(1'b0, 2'd0, 8, 1'b1, 32'h96, 8, 1'b0, mi);
    chk("t41_miso", mi, sb_tx.pop_front());
    chk("t41_und", 32'(und0), 32'd1);
    chk("t41_trdy_low", 32'(trdy_low0 - t), 32'd0);
    rx_take(1'b0, "t41_rx");

    // aborted partial word, then full frame
    c = rxv_cnt0;
    frame(1'b0, 2'd0, 8, 1'b1, 32'hFF, 5, 1'b0, mi);
    repeat (10) @(negedge clk);
    chk("t42_nvalid", 32'(rxv_cnt0 - c), 32'd0);
    chk("t42_busy", 32'(busy0), 32'd0);
    sb_rx.push_back(32'h81);
    frame(1'b0, 2'd0, 8, 1'b1, 32'h81, 8, 1'b0, mi);
    rx_take(1'b0, "t42_rx");
    chk("t42_rxd_hold", 32'(rxd0), 32'h81);

    // reset mid-frame with CS still asserted
    clr(1'b0);
    tx_load(1'b0, 16'h00FF);
    frame(1'b0, 2'd0, 8, 1'b1, 32'hF0, 3, 1'b1, mi);
    chk("t43_busy_pre", 32'(busy0), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("t43_rst", 32'({busy0, rxv0, miso0, trdy0, ovr0, und0}),
        32'b000100);
    chk("t43_rst_rxd", 32'(rxd0), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t43_no_restart", 32'(busy0), 32'd0);
    cs0 = 1'b0;
    repeat (8) @(negedge clk);
    tx_load(1'b0, 16'h0066);
    sb_rx.push_back(32'h42);
    sb_tx.push_back(32'h66);
    frame(1'b0, 2'd0, 8, 1'b1, 32'h42, 8, 1'b0, mi);
    chk("t43_miso", mi, sb_tx.pop_front());
    rx_take(1'b0, "t43_rx");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
